// File: rtl/memory_stage.sv
// memory_stage: data memory access plus the MEM/WB pipeline register.
// Optional feature macro SUBWORD_ACCESS_EN enables byte/halfword loads and
// stores selected by funct3M. Without it, every access is a full word.
// Memory contents are never reset. Reads are combinational and are captured
// into ReadDataW on the next rising edge.
module memory_stage #(
  parameter int DEPTH = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] WriteDataM,
  input  logic [31:0] PCPlus4M,
  input  logic [4:0]  RdM,
  input  logic        RegWriteM,
  input  logic        MemWriteM,
  input  logic [1:0]  ResultSrcM,
  input  logic [2:0]  funct3M,
  input  logic        StallW,
  input  logic        FlushW,
  output logic [31:0] ALUResultW,
  output logic [31:0] ReadDataW,
  output logic [31:0] PCPlus4W,
  output logic [4:0]  RdW,
  output logic        RegWriteW,
  output logic [1:0]  ResultSrcW,
  output logic        MisalignM
);

  localparam int AW = $clog2(DEPTH);

  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] widx;
  logic [1:0]    lane;
  logic [31:0]   rword;
  logic          mem_acc;
  logic          ld_mis;
  logic          st_en_p0;
  logic [3:0]    st_mask_p0;
  logic [31:0]   st_data_p0;
  logic [31:0]   ld_data_p0;
  logic          unused_bits;

  assign widx  = ALUResultM[AW+1:2];
  assign lane  = ALUResultM[1:0];
  assign rword = mem[widx];

`ifdef SUBWORD_ACCESS_EN
  assign unused_bits = ^ALUResultM[31:AW+2];

  // Misalignment rule: halfwords need addr[0]=0, words need addr[1:0]=0.
  function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] ln);
    case (f3[1:0])
      2'b00:   misaligned = 1'b0;
      2'b01:   misaligned = ln[0];
      default: misaligned = (ln != 2'b00);
    endcase
  endfunction

  // Extract the addressed byte/halfword and sign- or zero-extend it.
  function automatic logic [31:0] load_fmt(input logic [31:0] w, input logic [2:0] f3,
                                            input logic [1:0] ln);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    b = w[8*ln +: 8];
    h = w[16*ln[1] +: 16];
    case (f3[1:0])
      2'b00:   load_fmt = f3[2] ? {24'd0, b} : {{24{b[7]}}, b};
      2'b01:   load_fmt = f3[2] ? {16'd0, h} : {{16{h[15]}}, h};
      default: load_fmt = w;
    endcase
  endfunction

  // Byte-lane enables for a store of the given size at the given lane.
  function automatic logic [3:0] store_mask(input logic [2:0] f3, input logic [1:0] ln);
    case (f3[1:0])
      2'b00:   store_mask = 4'b0001 << ln;
      2'b01:   store_mask = ln[1] ? 4'b1100 : 4'b0011;
      default: store_mask = 4'b1111;
    endcase
  endfunction

  // Replicate the store data so every enabled lane sees the right bits.
  function automatic logic [31:0] store_data(input logic [2:0] f3, input logic [31:0] d);
    case (f3[1:0])
      2'b00:   store_data = {4{d[7:0]}};
      2'b01:   store_data = {2{d[15:0]}};
      default: store_data = d;
    endcase
  endfunction
`else
  assign unused_bits = ^{funct3M, ALUResultM[31:AW+2]};

  function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] ln);
    misaligned = (ln != 2'b00) | (1'b0 & f3[0]);
  endfunction

  function automatic logic [31:0] load_fmt(input logic [31:0] w, input logic [2:0] f3,
                                            input logic [1:0] ln);
    load_fmt = w | {32{1'b0 & (f3[0] | ln[0])}};
  endfunction

  function automatic logic [3:0] store_mask(input logic [2:0] f3, input logic [1:0] ln);
    store_mask = 4'b1111 | {4{1'b0 & (f3[0] | ln[0])}};
  endfunction

  function automatic logic [31:0] store_data(input logic [2:0] f3, input logic [31:0] d);
    store_data = d | {32{1'b0 & f3[0]}};
  endfunction
`endif

  // Stage p0: address decode, misalignment flag, load formatting, store enables.
  always_comb begin
    mem_acc    = MemWriteM | (ResultSrcM == 2'b01);
    MisalignM  = mem_acc & misaligned(funct3M, lane);
    ld_mis     = (ResultSrcM == 2'b01) & MisalignM;
    st_en_p0   = MemWriteM & ~StallW & ~rst & ~MisalignM;
    st_mask_p0 = store_mask(funct3M, lane);
    st_data_p0 = store_data(funct3M, WriteDataM);
    ld_data_p0 = load_fmt(rword, funct3M, lane);
  end

  // Byte-lane store commit; the read above sees pre-store contents this cycle.
  always_ff @(posedge clk) begin
    if (st_en_p0) begin
      for (int b = 0; b < 4; b++) begin
        if (st_mask_p0[b]) mem[widx][8*b +: 8] <= st_data_p0[8*b +: 8];
      end
    end
  end

  // Stage p1: MEM/WB register; reset and flush clear, stall holds.
  always_ff @(posedge clk) begin
    if (rst || FlushW) begin
      ALUResultW <= '0;
      ReadDataW  <= '0;
      PCPlus4W   <= '0;
      RdW        <= '0;
      RegWriteW  <= 1'b0;
      ResultSrcW <= '0;
    end else if (!StallW) begin
      ALUResultW <= ALUResultM;
      ReadDataW  <= ld_data_p0;
      PCPlus4W   <= PCPlus4M;
      RdW        <= RdM;
      RegWriteW  <= RegWriteM & ~ld_mis;
      ResultSrcW <= ResultSrcM;
    end
  end

endmodule

// File: tb/tb_memory_stage.sv
// Self-checking bench for memory_stage: byte-addressed reference model,
// directed scenarios with literal expectations, then randomized traffic.
module tb_memory_stage;
  localparam int DEPTH = 256;
  localparam int MB    = DEPTH * 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] ALUResultM, WriteDataM, PCPlus4M;
  logic [4:0]  RdM;
  logic        RegWriteM, MemWriteM;
  logic [1:0]  ResultSrcM;
  logic [2:0]  funct3M;
  logic        StallW, FlushW;
  logic [31:0] ALUResultW, ReadDataW, PCPlus4W;
  logic [4:0]  RdW;
  logic        RegWriteW;
  logic [1:0]  ResultSrcW;
  logic        MisalignM;

  memory_stage #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .ALUResultM(ALUResultM), .WriteDataM(WriteDataM),
    .PCPlus4M(PCPlus4M), .RdM(RdM), .RegWriteM(RegWriteM), .MemWriteM(MemWriteM),
    .ResultSrcM(ResultSrcM), .funct3M(funct3M), .StallW(StallW), .FlushW(FlushW),
    .ALUResultW(ALUResultW), .ReadDataW(ReadDataW), .PCPlus4W(PCPlus4W), .RdW(RdW),
    .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW), .MisalignM(MisalignM)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  // Reference model state: byte-addressed memory and expected W outputs.
  logic [7:0]  bmem   [MB];
  bit          bknown [MB];
  logic [31:0] exp_alu, exp_rdata, exp_pc;
  logic [4:0]  exp_rd;
  logic        exp_rw;
  logic [1:0]  exp_rs;
  bit          exp_rd_known;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
    end
  endtask

  function automatic int acc_size(input logic [2:0] f3);
`ifdef SUBWORD_ACCESS_EN
    case (f3[1:0])
      2'b00:   return 1;
      2'b01:   return 2;
      default: return 4;
    endcase
`else
    return 4 + 0 * int'(f3);
`endif
  endfunction

  function automatic logic mis_of(input logic [31:0] a, input logic mw, input logic [1:0] rs,
                                  input logic [2:0] f3);
    int sz;
    sz = acc_size(f3);
    return (mw || rs == 2'b01) && ((a % sz) != 0);
  endfunction

  // Load result: bytes of the size-aligned location, little-endian, extended.
  task automatic model_load(input logic [31:0] a, input logic [2:0] f3,
                            output logic [31:0] val, output bit known);
    int sz;
    int unsigned base;
    sz = acc_size(f3);
    base = (a % MB) / sz * sz;
    val = 0;
    known = 1;
    for (int i = 0; i < sz; i++) begin
      val = val | (32'(bmem[base + i]) << (8 * i));
      known = known && bknown[base + i];
    end
`ifdef SUBWORD_ACCESS_EN
    if (!f3[2] && sz < 4 && val[8*sz-1]) val = val | (32'hFFFF_FFFF << (8 * sz));
`endif
  endtask

  // Apply one rising edge to the model using the currently driven inputs.
  task automatic model_edge();
    logic [31:0] lv;
    bit          lk;
    logic        mis;
    int          sz;
    int unsigned base;
    mis = mis_of(ALUResultM, MemWriteM, ResultSrcM, funct3M);
    model_load(ALUResultM, funct3M, lv, lk);
    if (rst || FlushW) begin
      exp_alu = 0; exp_rdata = 0; exp_pc = 0; exp_rd = 0; exp_rw = 0; exp_rs = 0;
      exp_rd_known = 1;
    end else if (!StallW) begin
      exp_alu = ALUResultM; exp_rdata = lv; exp_rd_known = lk; exp_pc = PCPlus4M;
      exp_rd = RdM; exp_rs = ResultSrcM;
      exp_rw = RegWriteM && !(ResultSrcM == 2'b01 && mis);
    end
    if (MemWriteM && !StallW && !rst && !mis) begin
      sz = acc_size(funct3M);
      base = (ALUResultM % MB) / sz * sz;
      for (int i = 0; i < sz; i++) begin
        bmem[base + i]   = WriteDataM[8*i +: 8];
        bknown[base + i] = 1;
      end
    end
  endtask

  // Compare process: W outputs against the model every cycle once running.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("ALUResultW", ALUResultW, exp_alu);
      chk("PCPlus4W", PCPlus4W, exp_pc);
      chk("RdW", 32'(RdW), 32'(exp_rd));
      chk("RegWriteW", 32'(RegWriteW), 32'(exp_rw));
      chk("ResultSrcW", 32'(ResultSrcW), 32'(exp_rs));
      if (exp_rd_known) chk("ReadDataW", ReadDataW, exp_rdata);
    end
  end

  task automatic tick();
    #1;
    chk("MisalignM", 32'(MisalignM), 32'(mis_of(ALUResultM, MemWriteM, ResultSrcM, funct3M)));
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic idle();
    rst = 0; ALUResultM = 0; WriteDataM = 0; PCPlus4M = 0; RdM = 0; RegWriteM = 0;
    MemWriteM = 0; ResultSrcM = 2'b00; funct3M = 3'b010; StallW = 0; FlushW = 0;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [2:0] f3);
    idle(); ALUResultM = a; WriteDataM = d; MemWriteM = 1; funct3M = f3; tick();
  endtask

  task automatic load(input logic [31:0] a, input logic [2:0] f3);
    idle(); ALUResultM = a; ResultSrcM = 2'b01; funct3M = f3; RegWriteM = 1; RdM = 5'd7;
    PCPlus4M = 32'h100; tick();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < MB; i++) begin bmem[i] = 0; bknown[i] = 0; end
    idle();
    rst = 1; MemWriteM = 1; WriteDataM = 32'h5555_5555;
    tick();
    chk_en = 1;
    tick();
    chk("reset ALUResultW", ALUResultW, 32'h0);
    chk("reset ReadDataW", ReadDataW, 32'h0);
    chk("reset RegWriteW", 32'(RegWriteW), 32'h0);

    // Fill every word so later reads are defined.
    for (int i = 0; i < DEPTH; i++) store(32'(i * 4), $urandom, 3'b010);

    // SW then load next cycle.
    store(32'h10, 32'hDEAD_BEEF, 3'b010);
    load(32'h10, 3'b010);
    chk("sw/lw ReadDataW", ReadDataW, 32'hDEAD_BEEF);
    chk("sw/lw RegWriteW", 32'(RegWriteW), 32'h1);
    chk("sw/lw RdW", 32'(RdW), 32'd7);

`ifdef SUBWORD_ACCESS_EN
    store(32'h10, 32'h1122_3344, 3'b010);
    store(32'h13, 32'h0000_0080, 3'b000);
    load(32'h13, 3'b000);
    chk("LB", ReadDataW, 32'hFFFF_FF80);
    load(32'h13, 3'b100);
    chk("LBU", ReadDataW, 32'h0000_0080);
    load(32'h10, 3'b010);
    chk("LW after SB", ReadDataW, 32'h8022_3344);
    load(32'h12, 3'b101);
    chk("LHU", ReadDataW, 32'h0000_8022);
`endif

    // Stalled store: W frozen, single commit on release.
    store(32'h20, 32'h0BAD_F00D, 3'b010);
    load(32'h20, 3'b010);
    for (int k = 0; k < 3; k++) begin
      idle(); ALUResultM = 32'h24; WriteDataM = 32'hCAFE_F00D; MemWriteM = 1;
      PCPlus4M = 32'h200; StallW = 1; tick();
      chk("stall PCPlus4W", PCPlus4W, 32'h100);
      chk("stall ReadDataW", ReadDataW, 32'h0BAD_F00D);
    end
    load(32'h24, 3'b010);
    chk("stall no commit", ReadDataW == 32'hCAFE_F00D ? 32'h1 : 32'h0, 32'h0);
    store(32'h24, 32'hCAFE_F00D, 3'b010);
    load(32'h24, 3'b010);
    chk("stall release commit", ReadDataW, 32'hCAFE_F00D);

    // Flush beats stall.
    idle(); FlushW = 1; StallW = 1; RegWriteM = 1; RdM = 5'd5; ALUResultM = 32'h44; tick();
    chk("flush RegWriteW", 32'(RegWriteW), 32'h0);
    chk("flush RdW", 32'(RdW), 32'h0);

    // Misaligned store and address wrap.
    store(32'h4, 32'h1234_5678, 3'b010);
    store(32'h6, 32'hFFFF_FFFF, 3'b010);
    chk("misalign flag", 32'(MisalignM), 32'h1);
    load(32'h404, 3'b010);
    chk("wrap/misalign no write", ReadDataW, 32'h1234_5678);
    load(32'h6, 3'b010);
    chk("misaligned load RegWriteW", 32'(RegWriteW), 32'h0);

    // Reset mid-stream with a store pending.
    load(32'h30, 3'b010);
    idle(); rst = 1; MemWriteM = 1; ALUResultM = 32'h30; WriteDataM = 32'hA5A5_A5A5;
    PCPlus4M = 32'h300; RegWriteM = 1; RdM = 5'd9; ResultSrcM = 2'b10; tick();
    chk("rst ALUResultW", ALUResultW, 32'h0);
    chk("rst PCPlus4W", PCPlus4W, 32'h0);
    chk("rst RdW", 32'(RdW), 32'h0);
    chk("rst ResultSrcW", 32'(ResultSrcW), 32'h0);
    load(32'h30, 3'b010);
    chk("rst no commit", ReadDataW == 32'hA5A5_A5A5 ? 32'h1 : 32'h0, 32'h0);

    // Randomized traffic against the model.
    for (int n = 0; n < 2000; n++) begin
      logic [2:0] f3s [5];
      f3s = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
      idle();
      ALUResultM = $urandom_range(0, 2047);
      WriteDataM = $urandom;
      PCPlus4M   = $urandom;
      RdM        = 5'($urandom);
      RegWriteM  = 1'($urandom);
      MemWriteM  = ($urandom_range(0, 9) < 3);
      ResultSrcM = 2'($urandom_range(0, 2));
`ifdef SUBWORD_ACCESS_EN
      funct3M    = f3s[$urandom_range(0, 4)];
`else
      funct3M    = 3'($urandom);
`endif
      StallW     = ($urandom_range(0, 99) < 15);
      FlushW     = ($urandom_range(0, 99) < 10);
      rst        = ($urandom_range(0, 99) < 3);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
